asu_issue: RTL and testbench

Command queue and result register for the 8-bit add/shift unit (`asu_gate`). Upstream logic pushes `(mode, x, y)` commands through a valid/ready port into a DEPTH-entry FIFO. The block drives the FIFO head onto the ASU operand inputs and captures the combinational `{carry, out}` into a result register. A valid/ready port presents that result downstream, preserving command order.

---
 rtl/asu_issue_if.sv | 35 +++
 rtl/asu_issue.sv | 118 +++++++++++
 tb/tb_asu_issue.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/asu_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : asu_issue_if
// Description : Command, operand and result handshake bundle for asu_issue.
//               slave = asu_issue side, master = surrounding logic and ASU.
// Revision    : 1.0  initial release
// ============================================================================
interface asu_issue_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_mode;
  logic [7:0] cmd_x;
  logic [7:0] cmd_y;

  logic       asu_mode;
  logic [7:0] asu_x;
  logic [7:0] asu_y;
  logic       asu_carry;
  logic [7:0] asu_out;

  logic       res_valid;
  logic       res_ready;
  logic [8:0] res_data;

  modport master (
    output cmd_valid, cmd_mode, cmd_x, cmd_y, res_ready, asu_carry, asu_out,
    input  cmd_ready, asu_mode, asu_x, asu_y, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_x, cmd_y, res_ready, asu_carry, asu_out,
    output cmd_ready, asu_mode, asu_x, asu_y, res_valid, res_data
  );
endinterface
`default_nettype wire

// File: rtl/asu_issue.sv
`default_nettype none
// ============================================================================
// Module      : asu_issue
// Description : DEPTH-entry command FIFO feeding the add/shift unit, with a
//               valid/ready result register. Optional macro
//               ASU_ISSUE_STATS_EN adds pop and carry statistics counters.
// Revision    : 1.0  initial release
// ============================================================================
module asu_issue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  wire           clk,
  input  wire           rst_n,
  input  wire           flush,
  asu_issue_if.slave    bus,
  output logic [AW:0]   count
`ifdef ASU_ISSUE_STATS_EN
  ,
  output logic [15:0]   stat_issued,
  output logic [15:0]   stat_carry
`endif
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [16:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_res_valid;
  logic [8:0]    r_res_data;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;
  logic [16:0]   w_head;

  assign w_empty       = (r_count == '0);
  assign bus.cmd_ready = rst_n && !flush && (r_count != c_depth);
  assign w_push        = bus.cmd_valid && bus.cmd_ready;
  assign w_pop         = !w_empty && !flush && (!r_res_valid || bus.res_ready);

  // Head entry is driven straight to the ASU; zeros while empty.
  assign w_head = r_mem[r_rd_ptr];
  assign {bus.asu_mode, bus.asu_x, bus.asu_y} = w_empty ? 17'd0 : w_head;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + (AW+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.cmd_mode, bus.cmd_x, bus.cmd_y};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Flush leaves a pending result in place until it is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else if (w_pop) begin
      r_res_valid <= 1'b1;
      r_res_data  <= {bus.asu_carry, bus.asu_out};
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign count         = r_count;

`ifdef ASU_ISSUE_STATS_EN
  logic [15:0] r_stat_issued;
  logic [15:0] r_stat_carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_issued <= '0;
      r_stat_carry  <= '0;
    end else if (w_pop) begin
      r_stat_issued <= r_stat_issued + 16'd1;
      if (bus.asu_carry) begin
        r_stat_carry <= r_stat_carry + 16'd1;
      end
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_carry  = r_stat_carry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_asu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_asu_issue
// Description : Directed self-checking bench for asu_issue with an adder ASU
//               stub. Stats checks run when ASU_ISSUE_STATS_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_asu_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  asu_issue_if bus();

  assign {bus.asu_carry, bus.asu_out} = {1'b0, bus.asu_x} + {1'b0, bus.asu_y};

`ifdef ASU_ISSUE_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_carry;
`endif

  asu_issue #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .count (count)
`ifdef ASU_ISSUE_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_carry  (stat_carry)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic [7:0] x, input logic [7:0] y);
    bus.cmd_valid = v;
    bus.cmd_mode  = m;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.res_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_asu", {bus.asu_mode, bus.asu_x, bus.asu_y}, 0);
    rst_n = 1'b1;
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);

    // Single command, 1-cycle latency
    bus.res_ready = 1'b1;
    drive(1'b1, 1'b0, 8'hF0, 8'h20);
    tick();
    check("s1_count_acc", count, 1);
    check("s1_asu_x", bus.asu_x, 8'hF0);
    check("s1_asu_y", bus.asu_y, 8'h20);
    check("s1_valid_early", bus.res_valid, 0);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("s1_valid", bus.res_valid, 1);
    check("s1_data", bus.res_data, 9'h110);
    check("s1_count", count, 0);
    check("s1_asu_empty", bus.asu_x, 0);
    tick();
    check("s1_valid_clr", bus.res_valid, 0);

    // Backpressure: first result held, four queued, sixth refused
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'(16 + i), 8'h01);
      tick();
    end
    check("s2_count_full", count, 4);
    check("s2_cmd_ready", bus.cmd_ready, 0);
    check("s2_held_valid", bus.res_valid, 1);
    check("s2_held_data", bus.res_data, 9'h011);
    drive(1'b1, 1'b0, 8'h77, 8'h01);
    tick();
    check("s2_no_accept", count, 4);
    check("s2_held_data2", bus.res_data, 9'h011);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    bus.res_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("s2_drain_valid", bus.res_valid, 1);
      check("s2_drain_data", bus.res_data, 9'(9'h012 + j));
    end
    check("s2_count_empty", count, 0);
    tick();
    check("s2_done_valid", bus.res_valid, 0);

    // Continuous push/pop with pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'(i), 8'hFF);
      tick();
      check("s3_count", count, 1);
      if (i > 0) begin
        check("s3_valid", bus.res_valid, 1);
        check("s3_data", bus.res_data, 9'(9'h0FF + i - 1));
      end
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("s3_last_data", bus.res_data, 9'h108);
    check("s3_count_end", count, 0);
    tick();
    check("s3_valid_end", bus.res_valid, 0);

    // Flush with three queued and a pending result
    bus.res_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h03, 8'h00);
    tick();
    drive(1'b1, 1'b0, 8'h40, 8'h00);
    tick();
    drive(1'b1, 1'b0, 8'h41, 8'h00);
    tick();
    drive(1'b1, 1'b0, 8'h42, 8'h00);
    tick();
    check("s4_count_pre", count, 3);
    check("s4_pend_data", bus.res_data, 9'h003);
    drive(1'b1, 1'b0, 8'h50, 8'h00);
    flush = 1'b1;
    #1;
    check("s4_cmd_ready", bus.cmd_ready, 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    check("s4_count", count, 0);
    check("s4_pend_valid", bus.res_valid, 1);
    check("s4_pend_data2", bus.res_data, 9'h003);
    check("s4_asu_empty", bus.asu_x, 0);
    bus.res_ready = 1'b1;
    tick();
    check("s4_taken", bus.res_valid, 0);
    tick();
    check("s4_no_more", bus.res_valid, 0);
    check("s4_count_end", count, 0);

    // Mid-stream reset with two queued
    bus.res_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h01, 8'h01);
    tick();
    drive(1'b1, 1'b0, 8'h02, 8'h02);
    tick();
    drive(1'b1, 1'b0, 8'h03, 8'h03);
    tick();
    check("s5_count_pre", count, 2);
    check("s5_data_pre", bus.res_data, 9'h002);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("s5_valid", bus.res_valid, 0);
    check("s5_data", bus.res_data, 0);
    check("s5_count", count, 0);
    bus.res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("s5_no_stale", bus.res_valid, 0);
    end

`ifdef ASU_ISSUE_STATS_EN
    check("st_issued_rst", stat_issued, 0);
    check("st_carry_rst", stat_carry, 0);
    drive(1'b1, 1'b0, 8'h80, 8'h80);
    tick();
    drive(1'b1, 1'b0, 8'hFF, 8'h01);
    tick();
    drive(1'b1, 1'b0, 8'h01, 8'h01);
    tick();
    drive(1'b1, 1'b0, 8'h02, 8'h02);
    tick();
    drive(1'b1, 1'b0, 8'h03, 8'h03);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("st_issued", stat_issued, 5);
    check("st_carry", stat_carry, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("st_issued_clr", stat_issued, 0);
    check("st_carry_clr", stat_carry, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
